// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the RAM responder.
// Burst/response codes match the AXI4 wire encodings.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_slave_ram_mem.sv
// Simple dual-port word RAM: byte-enable write port, registered
// read port with enable; a same-word read and write returns old data.
module axi_slave_ram_mem #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [MEM_ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]               i_wdata,
    input  logic [3:0]                i_wstrb,
    input  logic                      i_re,
    input  logic [MEM_ADDR_WIDTH-1:0] i_raddr,
    output logic [31:0]               o_rdata
);

    logic [31:0] r_mem [2**MEM_ADDR_WIDTH];
    logic [31:0] r_rdata;

    // Byte-lane write and read-first registered read; contents never reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 RAM responder: independent write (AW/W/B) and read (AR/R)
// engines, one outstanding burst each, sharing a dual-port RAM.
module axi_slave_ram
    import axi_pkg::*;
#(
    parameter int ID_WIDTH       = 2,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                SLAVE_CLK,
    input  logic                SLAVE_RSTN,
    input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
    input  logic [31:0]         SLAVE_WR_ADDR,
    input  logic [7:0]          SLAVE_WR_ADDR_LEN,
    input  logic [1:0]          SLAVE_WR_ADDR_BURST,
    input  logic                SLAVE_WR_ADDR_VALID,
    output logic                SLAVE_WR_ADDR_READY,
    input  logic [31:0]         SLAVE_WR_DATA,
    input  logic [3:0]          SLAVE_WR_STRB,
    input  logic                SLAVE_WR_DATA_LAST,
    input  logic                SLAVE_WR_DATA_VALID,
    output logic                SLAVE_WR_DATA_READY,
    output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
    output logic [1:0]          SLAVE_WR_BACK_RESP,
    output logic                SLAVE_WR_BACK_VALID,
    input  logic                SLAVE_WR_BACK_READY,
    input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
    input  logic [31:0]         SLAVE_RD_ADDR,
    input  logic [7:0]          SLAVE_RD_ADDR_LEN,
    input  logic [1:0]          SLAVE_RD_ADDR_BURST,
    input  logic                SLAVE_RD_ADDR_VALID,
    output logic                SLAVE_RD_ADDR_READY,
    output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
    output logic [31:0]         SLAVE_RD_DATA,
    output logic [1:0]          SLAVE_RD_DATA_RESP,
    output logic                SLAVE_RD_DATA_LAST,
    output logic                SLAVE_RD_DATA_VALID,
    input  logic                SLAVE_RD_DATA_READY
);

    localparam int MAW = MEM_ADDR_WIDTH;

    // Word addresses carry one spare bit so INCR never wraps to zero
    function automatic logic f_oor(input logic [30:0] a);
        return a[30:MAW] != '0;
    endfunction

    wr_state_t           r_wstate, w_wstate_n;
    logic                r_awready, r_wready;
    logic                w_awready_n, w_wready_n;
    logic [ID_WIDTH-1:0] r_wid;
    logic [30:0]         r_waddr;
    logic [7:0]          r_wlen, r_wcnt;
    logic [1:0]          r_wburst;
    logic                r_werr;
    logic                w_aw_hs, w_w_hs, w_wbeat_err, w_mem_we;

    rd_state_t           r_rstate, w_rstate_n;
    logic                r_arready, w_arready_n;
    logic [ID_WIDTH-1:0] r_rid;
    logic [30:0]         r_raddr, w_raddr_nx, w_ar_addr;
    logic [7:0]          r_rlen, r_rcnt;
    logic [1:0]          r_rburst;
    logic                r_rerr;
    logic                w_ar_hs, w_rvalid, w_rlast, w_r_hs, w_mem_re;
    logic [MAW-1:0]      w_mem_raddr;
    logic [31:0]         w_mem_rdata;

    assign w_aw_hs     = SLAVE_WR_ADDR_VALID & r_awready;
    assign w_w_hs      = SLAVE_WR_DATA_VALID & r_wready;
    assign w_mem_we    = w_w_hs & ~f_oor(r_waddr);
    assign w_wbeat_err = f_oor(r_waddr) | r_wburst[1]
                       | ((r_wcnt == r_wlen) != SLAVE_WR_DATA_LAST);

    // Write FSM next state; READYs are registered from the next state
    always_comb begin
        w_wstate_n = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_n = W_DATA;
            W_DATA:  if (w_w_hs && SLAVE_WR_DATA_LAST) w_wstate_n = W_RESP;
            W_RESP:  if (SLAVE_WR_BACK_READY) w_wstate_n = W_IDLE;
            default: w_wstate_n = W_IDLE;
        endcase
        w_awready_n = (r_wstate == W_IDLE) && (w_wstate_n == W_IDLE);
        w_wready_n  = (w_wstate_n == W_DATA);
    end

    // Write FSM state and handshake registers
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_n;
            r_awready <= w_awready_n;
            r_wready  <= w_wready_n;
        end
    end

    // Write burst bookkeeping: latched AW fields, beat count, error flag
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid    <= SLAVE_WR_ADDR_ID;
            r_waddr  <= {1'b0, SLAVE_WR_ADDR[31:2]};
            r_wlen   <= SLAVE_WR_ADDR_LEN;
            r_wburst <= SLAVE_WR_ADDR_BURST;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else if (w_w_hs) begin
            r_wcnt <= r_wcnt + 8'd1;
            r_werr <= r_werr | w_wbeat_err;
            if (r_wburst != BURST_FIXED) r_waddr <= r_waddr + 31'd1;
        end
    end

    assign SLAVE_WR_ADDR_READY = r_awready;
    assign SLAVE_WR_DATA_READY = r_wready;
    assign SLAVE_WR_BACK_VALID = (r_wstate == W_RESP);
    assign SLAVE_WR_BACK_ID    = r_wid;
    assign SLAVE_WR_BACK_RESP  = (SLAVE_WR_BACK_VALID && r_werr)
                               ? RESP_SLVERR : RESP_OKAY;

    assign w_ar_hs    = SLAVE_RD_ADDR_VALID & r_arready;
    assign w_ar_addr  = {1'b0, SLAVE_RD_ADDR[31:2]};
    assign w_rvalid   = (r_rstate == R_DATA);
    assign w_rlast    = w_rvalid && (r_rcnt == r_rlen);
    assign w_r_hs     = w_rvalid & SLAVE_RD_DATA_READY;
    assign w_raddr_nx = (r_rburst == BURST_FIXED) ? r_raddr
                                                  : r_raddr + 31'd1;
    assign w_mem_re    = w_ar_hs | (w_r_hs & ~w_rlast);
    assign w_mem_raddr = w_ar_hs ? w_ar_addr[MAW-1:0]
                                 : w_raddr_nx[MAW-1:0];

    // Read FSM next state and registered ARREADY
    always_comb begin
        w_rstate_n = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_n = R_DATA;
            R_DATA:  if (w_r_hs && w_rlast) w_rstate_n = R_IDLE;
            default: w_rstate_n = R_IDLE;
        endcase
        w_arready_n = (r_rstate == R_IDLE) && (w_rstate_n == R_IDLE);
    end

    // Read FSM state and handshake register
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_n;
            r_arready <= w_arready_n;
        end
    end

    // Read burst bookkeeping; error flag tracks the beat being presented
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_rerr   <= 1'b0;
        end else if (w_ar_hs) begin
            r_rid    <= SLAVE_RD_ADDR_ID;
            r_raddr  <= w_ar_addr;
            r_rlen   <= SLAVE_RD_ADDR_LEN;
            r_rburst <= SLAVE_RD_ADDR_BURST;
            r_rcnt   <= '0;
            r_rerr   <= f_oor(w_ar_addr) | SLAVE_RD_ADDR_BURST[1];
        end else if (w_r_hs && !w_rlast) begin
            r_raddr <= w_raddr_nx;
            r_rcnt  <= r_rcnt + 8'd1;
            r_rerr  <= f_oor(w_raddr_nx) | r_rburst[1];
        end
    end

    assign SLAVE_RD_ADDR_READY = r_arready;
    assign SLAVE_RD_DATA_VALID = w_rvalid;
    assign SLAVE_RD_BACK_ID    = r_rid;
    assign SLAVE_RD_DATA_LAST  = w_rlast;
    assign SLAVE_RD_DATA_RESP  = (w_rvalid && r_rerr) ? RESP_SLVERR
                                                      : RESP_OKAY;
    assign SLAVE_RD_DATA       = (w_rvalid && !r_rerr) ? w_mem_rdata
                                                       : 32'd0;

    logic w_unused;
    assign w_unused = &{1'b0, SLAVE_WR_ADDR[1:0], SLAVE_RD_ADDR[1:0]};

    axi_slave_ram_mem #(
        .MEM_ADDR_WIDTH(MAW)
    ) u_mem (
        .i_clk  (SLAVE_CLK),
        .i_we   (w_mem_we),
        .i_waddr(r_waddr[MAW-1:0]),
        .i_wdata(SLAVE_WR_DATA),
        .i_wstrb(SLAVE_WR_STRB),
        .i_re   (w_mem_re),
        .i_raddr(w_mem_raddr),
        .o_rdata(w_mem_rdata)
    );

endmodule

// File: tb/tb_axi_slave_ram.sv
// Bench for axi_slave_ram: directed and random bursts checked against
// a word-array model of the RAM and the AXI response rules.
module tb_axi_slave_ram;
    import axi_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  aw_id = '0, ar_id = '0, b_id, r_id;
    logic [31:0] aw_addr = '0, ar_addr = '0, w_data = '0, r_data;
    logic [7:0]  aw_len = '0, ar_len = '0;
    logic [1:0]  aw_burst = '0, ar_burst = '0, b_resp, r_resp;
    logic [3:0]  w_strb = '0;
    logic        aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready;
    logic        b_valid, b_ready = 0, ar_valid = 0, ar_ready;
    logic        r_last, r_valid, r_ready = 0;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    axi_slave_ram #(.ID_WIDTH(2), .MEM_ADDR_WIDTH(10)) dut (
        .SLAVE_CLK(clk), .SLAVE_RSTN(rst_n),
        .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr),
        .SLAVE_WR_ADDR_LEN(aw_len), .SLAVE_WR_ADDR_BURST(aw_burst),
        .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
        .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb),
        .SLAVE_WR_DATA_LAST(w_last), .SLAVE_WR_DATA_VALID(w_valid),
        .SLAVE_WR_DATA_READY(w_ready),
        .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp),
        .SLAVE_WR_BACK_VALID(b_valid), .SLAVE_WR_BACK_READY(b_ready),
        .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr),
        .SLAVE_RD_ADDR_LEN(ar_len), .SLAVE_RD_ADDR_BURST(ar_burst),
        .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
        .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data),
        .SLAVE_RD_DATA_RESP(r_resp), .SLAVE_RD_DATA_LAST(r_last),
        .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word touched by beat i of a burst, as a plain unbounded integer
    function automatic int word_of(input logic [31:0] addr,
                                   input logic [1:0] burst, input int i);
        return int'(addr >> 2) + ((burst == BURST_FIXED) ? 0 : i);
    endfunction

    function automatic logic beat_bad(input int a, input logic [1:0] burst);
        return (a >= DEPTH) || (burst >= 2'd2);
    endfunction

    task automatic do_write(input logic [1:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] burst,
                            input int last_at);
        int n;
        int a;
        logic err;
        @(negedge clk);
        aw_id = id; aw_addr = addr; aw_len = 8'(len);
        aw_burst = burst; aw_valid = 1'b1;
        n = 0;
        while (!aw_ready && n < 100) begin @(negedge clk); n++; end
        chk("aw_timeout", 64'(n < 100), 64'(1));
        @(posedge clk); #1 aw_valid = 1'b0;
        err = 1'b0;
        for (int b = 0; b <= last_at; b++) begin
            @(negedge clk);
            w_data = wd[b]; w_strb = ws[b];
            w_last = (b == last_at); w_valid = 1'b1;
            n = 0;
            while (!w_ready && n < 100) begin @(negedge clk); n++; end
            chk("w_timeout", 64'(n < 100), 64'(1));
            @(posedge clk); #1 w_valid = 1'b0; w_last = 1'b0;
            a = word_of(addr, burst, b);
            if (beat_bad(a, burst)) err = 1'b1;
            if (a < DEPTH) begin
                for (int j = 0; j < 4; j++)
                    if (ws[b][j]) mdl[a][8*j +: 8] = wd[b][8*j +: 8];
            end
            if ((b == len) != (b == last_at)) err = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!b_valid && n < 100) begin @(negedge clk); n++; end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("b_resp", 64'({b_valid, b_id, b_resp}),
            64'({1'b1, id, err ? RESP_SLVERR : RESP_OKAY}));
        b_ready = 1'b1;
        @(posedge clk); #1 b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] id, input logic [31:0] addr,
                           input int len, input logic [1:0] burst,
                           input int stall_pct);
        int n;
        int beat;
        int a;
        logic bad;
        logic stalled;
        logic [34:0] held;
        logic [36:0] e;
        @(negedge clk);
        ar_id = id; ar_addr = addr; ar_len = 8'(len);
        ar_burst = burst; ar_valid = 1'b1;
        n = 0;
        while (!ar_ready && n < 100) begin @(negedge clk); n++; end
        chk("ar_timeout", 64'(n < 100), 64'(1));
        @(posedge clk); #1 ar_valid = 1'b0;
        beat = 0; n = 0; stalled = 1'b0; held = '0;
        while (beat <= len && n < 4000) begin
            @(negedge clk); n++;
            if (stalled)
                chk("r_stable", 64'({r_data, r_resp, r_last}), 64'(held));
            r_ready = ($urandom_range(0, 99) >= stall_pct);
            stalled = 1'b0;
            if (r_valid && r_ready) begin
                a = word_of(addr, burst, beat);
                bad = beat_bad(a, burst);
                e = {id, bad ? RESP_SLVERR : RESP_OKAY, beat == len,
                     bad ? 32'd0 : mdl[a]};
                chk("r_beat", 64'({r_id, r_resp, r_last, r_data}), 64'(e));
                last_rdata = r_data;
                beat++;
            end else if (r_valid) begin
                stalled = 1'b1;
                held = {r_data, r_resp, r_last};
            end
        end
        chk("r_count", 64'(beat), 64'(len + 1));
        @(posedge clk); #1 r_ready = 1'b0;
        chk("r_done", 64'(r_valid), 64'(0));
    endtask

    initial begin
        int n;
        int beats;
        logic [1:0] bt;
        logic [31:0] ad;
        int ln;

        #12;
        chk("rst_outs", 64'({aw_ready, w_ready, b_valid, ar_ready,
                             r_valid, r_last, b_id, b_resp, r_id, r_resp}),
            64'(0));
        chk("rst_rdata", 64'(r_data), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 64'({aw_ready, ar_ready, w_ready}),
            64'(3'b110));

        // fill the whole RAM so every model word is known
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = $urandom; ws[i] = 4'hF;
            end
            do_write(2'(blk), 32'(blk * 1024), 255, BURST_INCR, 255);
        end

        // 256-beat INCR write of 0..255 then readback
        for (int i = 0; i < 256; i++) begin wd[i] = i; ws[i] = 4'hF; end
        do_write(2'd1, 32'h0, 255, BURST_INCR, 255);
        do_read(2'd1, 32'h0, 255, BURST_INCR, 0);

        // byte strobes merge into existing word
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(2'd0, 32'h10, 0, BURST_INCR, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(2'd0, 32'h10, 0, BURST_INCR, 0);
        do_read(2'd0, 32'h10, 0, BURST_INCR, 0);
        chk("strb_merge", 64'(last_rdata), 64'(32'hAA22CC44));

        // back-pressured read
        do_read(2'd2, 32'h40, 15, BURST_INCR, 50);

        // burst crossing the top of the RAM
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(2'd3, 32'h0FF8, 3, BURST_INCR, 3);
        do_read(2'd3, 32'h0FF8, 3, BURST_INCR, 0);

        // early WLAST closes burst with SLVERR; next burst is clean
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(2'd2, 32'h200, 3, BURST_INCR, 2);
        do_write(2'd1, 32'h300, 0, BURST_INCR, 0);
        do_read(2'd2, 32'h200, 3, BURST_INCR, 20);

        // random bursts, occasionally WRAP or running off the end
        for (int k = 0; k < 14; k++) begin
            bt = ($urandom_range(0, 7) == 0) ? BURST_WRAP
                                             : 2'($urandom_range(0, 1));
            ln = $urandom_range(0, 15);
            ad = 32'($urandom_range(0, DEPTH + 7)) << 2;
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom; ws[i] = 4'($urandom);
            end
            do_write(2'($urandom), ad, ln, bt, ln);
            do_read(2'($urandom), ad, ln, bt, 30);
        end

        // reset in the middle of a 16-beat read
        @(negedge clk);
        ar_id = 2'd1; ar_addr = 32'h80; ar_len = 8'd15;
        ar_burst = BURST_INCR; ar_valid = 1'b1;
        n = 0;
        while (!ar_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 ar_valid = 1'b0; r_ready = 1'b1;
        beats = 0; n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (r_valid) begin
                if (beats == 5) break;
                beats++;
            end
        end
        chk("pre_rst_beats", 64'(beats), 64'(5));
        r_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({r_valid, ar_ready, aw_ready}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst2", 64'({ar_ready, aw_ready, r_valid, b_valid}),
            64'(4'b1100));
        do_read(2'd1, 32'h80, 15, BURST_INCR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 responder (slave) with an internal word-addressed RAM: accepts write and read bursts from a master, stores/returns 32-bit data, and issues write responses.
- Opposite end of the bus from the team's simulation master; serves as the default memory-mapped target behind the interconnect and as a synthesizable loopback target for master/interconnect regression.
- Write and read channels are fully independent (one outstanding transaction each, concurrent).

Parameters:
- ID_WIDTH, 2, width of AW/AR/B/R ID fields.
- MEM_ADDR_WIDTH, 10, RAM depth = 2**MEM_ADDR_WIDTH 32-bit words; byte address bits [MEM_ADDR_WIDTH+1:2] index the RAM.

Ports:
- SLAVE_CLK in 1 clock; one clock domain.
- SLAVE_RSTN in 1 reset, asynchronous, active-low.
- SLAVE_WR_ADDR_ID in ID_WIDTH; SLAVE_WR_ADDR in 32; SLAVE_WR_ADDR_LEN in 8 (beats-1); SLAVE_WR_ADDR_BURST in 2; SLAVE_WR_ADDR_VALID in 1; SLAVE_WR_ADDR_READY out 1.
- SLAVE_WR_DATA in 32; SLAVE_WR_STRB in 4; SLAVE_WR_DATA_LAST in 1; SLAVE_WR_DATA_VALID in 1; SLAVE_WR_DATA_READY out 1.
- SLAVE_WR_BACK_ID out ID_WIDTH; SLAVE_WR_BACK_RESP out 2; SLAVE_WR_BACK_VALID out 1; SLAVE_WR_BACK_READY in 1.
- SLAVE_RD_ADDR_ID in ID_WIDTH; SLAVE_RD_ADDR in 32; SLAVE_RD_ADDR_LEN in 8; SLAVE_RD_ADDR_BURST in 2; SLAVE_RD_ADDR_VALID in 1; SLAVE_RD_ADDR_READY out 1.
- SLAVE_RD_BACK_ID out ID_WIDTH; SLAVE_RD_DATA out 32; SLAVE_RD_DATA_RESP out 2; SLAVE_RD_DATA_LAST out 1; SLAVE_RD_DATA_VALID out 1; SLAVE_RD_DATA_READY in 1.

Behaviour:
- Reset (SLAVE_RSTN=0, async): both FSMs to IDLE; all READY/VALID/LAST outputs 0; IDs, RESP, RDATA 0. READYs are registered and first rise on the first clock edge after reset release. RAM contents are not reset and survive reset. Reset mid-burst aborts it silently: no B or remaining R beats are produced.
- Burst types: FIXED (00) keeps the address; INCR (01) adds one word per beat. WRAP (10) and reserved (11) are treated as INCR with every beat flagged SLVERR.
- Address check: a beat is in range iff word address < 2**MEM_ADDR_WIDTH. INCR bursts are computed on a 30-bit word address with no wrap, so crossing the top goes out of range.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1; on the AW handshake, latch ID/addr/len/burst, clear err, go to W_DATA (AWREADY=0).
  - W_DATA: WREADY=1. Each W handshake writes the enabled byte lanes (STRB bit i -> byte i) when in range; out-of-range beats are dropped and set err. A beat counter compares against LEN. WLAST arriving early, or a beat past LEN without WLAST, sets err. The burst ends only on the WLAST handshake -> W_RESP, with WREADY low the next cycle.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=err?10:00; hold until BREADY, then W_IDLE.
  - Minimum write turnaround: AW, (LEN+1) W beats, B, 1 idle cycle before the next AWREADY.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. The AR handshake at edge T latches fields and issues a RAM read of the start word; RVALID=1 from after T.
  - R_DATA: RID=latched ID. RLAST=1 iff beat count == LEN. RRESP=10 and RDATA=0 for out-of-range or WRAP/reserved beats, else 00 and RAM data.
  - On a non-last R handshake, the next word's read is issued in the same cycle and RVALID stays 1, giving one beat per cycle under RREADY=1.
  - While RREADY=0, RDATA/RRESP/RLAST hold stable (RAM read-enable low).
  - Last handshake -> R_IDLE, RVALID=0.
- Simultaneous same-word write and read in one cycle: the read returns old data (read-first).
- AW and AR may handshake in the same cycle; the channels never stall each other.

Decomposition:
- Shared package axi_pkg: BURST_FIXED/INCR/WRAP encodings, RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, write/read state enums.
- Sub-module axi_slave_ram_mem: simple dual-port RAM with one byte-enable write port, one read port with read enable, 1-cycle read-first latency, parameter MEM_ADDR_WIDTH.

Test Plan:
- Write ID 01, addr 0x0, LEN 255, INCR, data 0..255, STRB 1111, then read the same burst -> B ID 01 RESP 00; 256 R beats with data 0..255, RLAST on beat 255 only, RRESP 00.
- Write word 0x10=0xAABBCCDD, then single write to 0x10 with STRB 0101, data 0x11223344 -> readback 0xAA22CC44.
- Read LEN 15 INCR with RREADY randomly low 50% -> data sequence unchanged, RDATA stable during every stall, no lost or duplicated beats.
- Write LEN 3 to byte addr 0x0FF8 (MEM_ADDR_WIDTH 10) -> words 0x3FE/0x3FF written, BRESP 10; read the same -> beats 0-1 RESP 00, beats 2-3 RESP 10 with data 0.
- WLAST asserted on beat 2 of a LEN 3 burst -> burst closes there, BRESP 10; next AW accepted normally.
- SLAVE_RSTN pulsed low mid read burst (beat 5 of 16) -> RVALID drops asynchronously; after release ARREADY rises next edge; earlier-written RAM data reads back intact.
